// File: rtl/twos_to_signmag_serial.sv
// ---------------------------------------------------------------------------
// twos_to_signmag_serial
//
// Bit-serial two's-complement to sign-magnitude converter. One operand is
// captured per transaction, then walked LSB first over WIDTH shift cycles
// using the copy-to-first-1-then-invert rule. A "seen a one" flag stands in
// for the carry chain of a conventional negate. The result is presented as
// {out_sign, out_mag} with a valid/ready handshake. Transactions do not
// overlap: a new operand is taken only in IDLE.
//
// Parameters
//   WIDTH      operand and magnitude width in bits (>= 2)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (async assert, sync release)
//   in_valid   operand valid
//   in_ready   converter idle and able to accept an operand
//   in_data    two's-complement operand, sampled on the acceptance edge
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts the result
//   out_sign   1 = negative
//   out_mag    unsigned magnitude
//   out_ovf    saturation flag for the most-negative input
//
// Configuration macro
//   SAT_MIN_EN  when defined, the most-negative operand saturates to
//               2^(WIDTH-1)-1 and raises out_ovf for that result. When
//               undefined, out_ovf is tied low and the most-negative operand
//               converts to its exact magnitude 2^(WIDTH-1).
// ---------------------------------------------------------------------------
module twos_to_signmag_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             stateCur;
    state_t             stateNext;

    logic [CNT_W-1:0]   bitCnt;
    logic               seenOne;
    logic [WIDTH-1:0]   shiftReg;
    logic               signReg;
    logic [WIDTH-1:0]   magReg;

    logic               accept;
    logic               lastBit;
    logic               curBit;
    logic               magBit;

    assign accept  = in_valid & in_ready;
    assign lastBit = (bitCnt == CNT_W'(WIDTH - 1));
    assign curBit  = shiftReg[0];
    // Bits up to and including the first 1 are copied; later bits of a
    // negative operand are inverted.
    assign magBit  = (signReg & seenOne) ? ~curBit : curBit;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateCur <= IDLE;
        end else begin
            stateCur <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = stateCur;
        case (stateCur)
            IDLE:    if (accept)    stateNext = SHIFT;
            SHIFT:   if (lastBit)   stateNext = DONE;
            DONE:    if (out_ready) stateNext = IDLE;
            default:                stateNext = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (stateCur == IDLE);
        out_valid = (stateCur == DONE);
    end

    // Serial datapath
`ifdef SAT_MIN_EN
    logic ovfReg;
    // Most-negative operand: sign set and no 1 in bits [WIDTH-2:0], which is
    // exactly the state of seenOne while the MSB is being processed.
    logic satHit;
    assign satHit = lastBit & signReg & ~seenOne;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shiftReg <= '0;
            signReg  <= 1'b0;
            seenOne  <= 1'b0;
            bitCnt   <= '0;
            magReg   <= '0;
            ovfReg   <= 1'b0;
        end else begin
            case (stateCur)
                IDLE: begin
                    if (accept) begin
                        shiftReg <= in_data;
                        signReg  <= in_data[WIDTH-1];
                        seenOne  <= 1'b0;
                        bitCnt   <= '0;
                        ovfReg   <= 1'b0;
                    end
                end
                SHIFT: begin
                    shiftReg <= shiftReg >> 1;
                    seenOne  <= seenOne | curBit;
                    if (satHit) begin
                        magReg <= {1'b0, {(WIDTH-1){1'b1}}};
                        ovfReg <= 1'b1;
                    end else begin
                        magReg <= {magBit, magReg[WIDTH-1:1]};
                    end
                    if (!lastBit) bitCnt <= bitCnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_ovf = ovfReg;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shiftReg <= '0;
            signReg  <= 1'b0;
            seenOne  <= 1'b0;
            bitCnt   <= '0;
            magReg   <= '0;
        end else begin
            case (stateCur)
                IDLE: begin
                    if (accept) begin
                        shiftReg <= in_data;
                        signReg  <= in_data[WIDTH-1];
                        seenOne  <= 1'b0;
                        bitCnt   <= '0;
                    end
                end
                SHIFT: begin
                    shiftReg <= shiftReg >> 1;
                    seenOne  <= seenOne | curBit;
                    // Magnitude enters from the MSB so that after WIDTH
                    // cycles operand bit 0 sits in magnitude bit 0.
                    magReg   <= {magBit, magReg[WIDTH-1:1]};
                    if (!lastBit) bitCnt <= bitCnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_ovf = 1'b0;
`endif

    assign out_sign = signReg;
    assign out_mag  = magReg;

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
module tb_twos_to_signmag_serial;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [WIDTH-1:0] out_mag;
    logic             out_ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic             sign;
        logic [WIDTH-1:0] mag;
        logic             ovf;
        logic [WIDTH-1:0] din;
    } exp_t;

    exp_t expQ[$];

    twos_to_signmag_serial #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: a result is consumed on the edge following a
    // negedge that sees out_valid & out_ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    check("unexpected_result", 32'(out_mag), 32'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    check($sformatf("sign_in%02h", e.din), 32'(out_sign), 32'(e.sign));
                    check($sformatf("mag_in%02h", e.din),  32'(out_mag),  32'(e.mag));
                    check($sformatf("ovf_in%02h", e.din),  32'(out_ovf),  32'(e.ovf));
                end
            end
        end
    end

    // Watchdog
    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input logic [WIDTH-1:0] d, input logic s,
                                input logic [WIDTH-1:0] m, input logic o);
        exp_t e;
        e.din = d; e.sign = s; e.mag = m; e.ovf = o;
        return e;
    endfunction

    task automatic waitReady();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Offer one operand; returns just after the acceptance edge.
    task automatic send(input logic [WIDTH-1:0] d);
        waitReady();
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (!(in_ready && !out_valid && expQ.size() == 0) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_done", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        // Reset state
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sign",  32'(out_sign),  32'd0);
        check("rst_out_mag",   32'(out_mag),   32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: latency and return to idle
        expQ.push_back(mk(8'h05, 1'b0, 8'h05, 1'b0));
        send(8'h05);
        for (int i = 1; i <= WIDTH; i++) begin
            if (i == 1) check("shift_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            if (i == WIDTH - 1) check("lat_not_early", 32'(out_valid), 32'd0);
            if (i == WIDTH)     check("lat_valid",     32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        check("t1_in_ready_back", 32'(in_ready),  32'd1);
        check("t1_valid_dropped", 32'(out_valid), 32'd0);
        check("t1_mag_held",      32'(out_mag),   32'h05);

        // Test 2 / 3: negative values and most-negative
        expQ.push_back(mk(8'hFB, 1'b1, 8'h05, 1'b0)); send(8'hFB);
        expQ.push_back(mk(8'hFF, 1'b1, 8'h01, 1'b0)); send(8'hFF);
        expQ.push_back(mk(8'h7F, 1'b0, 8'h7F, 1'b0)); send(8'h7F);
`ifdef SAT_MIN_EN
        expQ.push_back(mk(8'h80, 1'b1, 8'h7F, 1'b1)); send(8'h80);
`else
        expQ.push_back(mk(8'h80, 1'b1, 8'h80, 1'b0)); send(8'h80);
`endif
        expQ.push_back(mk(8'h01, 1'b0, 8'h01, 1'b0)); send(8'h01);
        drain();

        // Test 4: zero, then in_valid held through SHIFT is not taken early
        expQ.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0));
        expQ.push_back(mk(8'h81, 1'b1, 8'h7F, 1'b0));
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(posedge clk); #1;
        in_data  = 8'h81;
        repeat (3) @(posedge clk);
        #1 check("t4_busy_in_ready", 32'(in_ready), 32'd0);
        waitReady();
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Test 5: backpressure in DONE
        out_ready = 1'b0;
        expQ.push_back(mk(8'hC8, 1'b1, 8'h38, 1'b0));
        send(8'hC8);
        repeat (WIDTH - 1) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t5_hold_valid",    32'(out_valid), 32'd1);
            check("t5_hold_mag",      32'(out_mag),   32'h38);
            check("t5_hold_in_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t5_released", 32'(out_valid), 32'd0);
        drain();

        // Test 6: asynchronous reset mid-SHIFT aborts the transaction
        send(8'hB3);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid",    32'(out_valid), 32'd0);
        check("t6_rst_sign",     32'(out_sign),  32'd0);
        check("t6_rst_mag",      32'(out_mag),   32'd0);
        check("t6_rst_in_ready", 32'(in_ready),  32'd1);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        expQ.push_back(mk(8'h9C, 1'b1, 8'h64, 1'b0));
        send(8'h9C);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
